// File: rtl/lcd_pkg.sv
// HD44780 command set, power-up init table, FSM encoding and bus word type
// shared by the LCD arbiter and its slot timer.
package lcd_pkg;

  localparam logic [7:0] CMD_FUNCTION_SET = 8'h38;
  localparam logic [7:0] CMD_DISPLAY_OFF  = 8'h08;
  localparam logic [7:0] CMD_CLEAR        = 8'h01;
  localparam logic [7:0] CMD_ENTRY_MODE   = 8'h06;
  localparam logic [7:0] CMD_DISPLAY_ON   = 8'h0C;
  localparam logic [7:0] CMD_RETURN_HOME  = 8'h02;
  localparam logic [7:0] CMD_SET_LINE1    = 8'h80;
  localparam logic [7:0] CMD_SET_LINE2    = 8'hC0;

  localparam int INIT_LEN = 6;

  // Entry [0] is issued first.
  localparam logic [INIT_LEN-1:0][7:0] INIT_TABLE = {
    CMD_RETURN_HOME,
    CMD_DISPLAY_ON,
    CMD_ENTRY_MODE,
    CMD_CLEAR,
    CMD_DISPLAY_OFF,
    CMD_FUNCTION_SET
  };

  typedef enum logic [1:0] {
    ST_INIT_WAIT = 2'd0,
    ST_INIT_CMD  = 2'd1,
    ST_IDLE      = 2'd2,
    ST_SLOT      = 2'd3
  } lcd_state_e;

  typedef struct packed {
    logic       rs;
    logic [7:0] data;
  } lcd_wr_t;

  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/lcd_slot_timer.sv
// Slot timebase: counts cycles into ticks and ticks into slots while run is high,
// flags the last cycle of a slot and the tick-1 enable window; idles at zero otherwise.
module lcd_slot_timer #(
  parameter int TICK_CYC   = 100_000,
  parameter int SLOT_TICKS = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic slot_done,
  output logic e_window
);

  localparam int CW = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
  localparam int SW = (SLOT_TICKS > 1) ? $clog2(SLOT_TICKS) : 1;
  localparam logic [CW-1:0] CYC_LAST  = CW'(TICK_CYC - 1);
  localparam logic [SW-1:0] TICK_LAST = SW'(SLOT_TICKS - 1);

  logic [CW-1:0] cyc_cnt;
  logic [SW-1:0] tick_cnt;
  logic          tick;

  assign tick      = run && (cyc_cnt == CYC_LAST);
  assign slot_done = tick && (tick_cnt == TICK_LAST);
  assign e_window  = run && (tick_cnt == SW'(1));

  // Dropping run snaps the counters back so the next slot always starts at cycle 0.
  always_ff @(posedge clk) begin
    if (reset || !run) begin
      cyc_cnt  <= '0;
      tick_cnt <= '0;
    end else if (tick) begin
      cyc_cnt  <= '0;
      tick_cnt <= slot_done ? '0 : tick_cnt + 1'b1;
    end else begin
      cyc_cnt  <= cyc_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/lcd_bus_arbiter.sv
// Two-requester HD44780 bus arbiter: runs the power-up init, then grants one write per slot
// round-robin with burst locking; req_ready is a one-cycle accept in IDLE, requests otherwise wait.
module lcd_bus_arbiter
  import lcd_pkg::*;
#(
  parameter int TICK_CYC        = 100_000,
  parameter int SLOT_TICKS      = 4,
  parameter int INIT_WAIT_SLOTS = 5,
  parameter int LOCK_SLOTS      = 40
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req_valid,
  input  logic [1:0]  req_rs,
  input  logic [15:0] req_data,
  input  logic [1:0]  req_last,
  output logic [1:0]  req_ready,
  output logic        lcd_e,
  output logic        lcd_rs,
  output logic        lcd_rw,
  output logic [7:0]  lcd_data,
  output logic        init_done,
  output logic [1:0]  grant
);

  localparam int WW = (INIT_WAIT_SLOTS > 0) ? $clog2(INIT_WAIT_SLOTS + 1) : 1;
  localparam int LW = (LOCK_SLOTS > 0) ? $clog2(LOCK_SLOTS + 1) : 1;
  localparam logic [WW-1:0] WAIT_LAST = WW'(INIT_WAIT_SLOTS - 1);
  localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_SLOTS - 1);
  localparam logic [2:0]    INIT_LAST = 3'(INIT_LEN - 1);

  lcd_state_e    state;
  lcd_state_e    state_nxt;
  logic          slot_done;
  logic          e_window;
  logic          run;
  logic          lock;
  logic          last_ptr;
  logic [WW-1:0] wait_cnt;
  logic [LW-1:0] idle_slots;
  logic [2:0]    init_idx;
  lcd_wr_t       wr_q;
  logic [1:0]    eligible;
  logic          win;
  logic          accept;
  logic          owner_valid;
  logic          idle_hold;
  logic          timeout;

  lcd_slot_timer #(
    .TICK_CYC   (TICK_CYC),
    .SLOT_TICKS (SLOT_TICKS)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .run       (run),
    .slot_done (slot_done),
    .e_window  (e_window)
  );

  // While locked, grant holds the owner, so masking with it restricts arbitration to the owner.
  assign owner_valid = |(req_valid & grant);
  assign eligible    = lock ? (req_valid & grant) : req_valid;
  assign win         = (eligible == 2'b11) ? ~last_ptr : eligible[1];
  assign accept      = (state == ST_IDLE) && (eligible != 2'b00);
  assign idle_hold   = (state == ST_IDLE) && lock && !owner_valid;
  assign timeout     = idle_hold && slot_done && (idle_slots == LOCK_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_INIT_WAIT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_INIT_WAIT: if (slot_done && (wait_cnt == WAIT_LAST)) state_nxt = ST_INIT_CMD;
      ST_INIT_CMD:  if (slot_done && (init_idx == INIT_LAST)) state_nxt = ST_IDLE;
      ST_IDLE:      if (accept) state_nxt = ST_SLOT;
      ST_SLOT:      if (slot_done) state_nxt = ST_IDLE;
      default:      state_nxt = ST_INIT_WAIT;
    endcase
  end

  always_comb begin
    lcd_e     = 1'b0;
    req_ready = 2'b00;
    run       = 1'b0;
    case (state)
      ST_INIT_WAIT: run = 1'b1;
      ST_INIT_CMD: begin
        run   = 1'b1;
        lcd_e = e_window;
      end
      ST_SLOT: begin
        run   = 1'b1;
        lcd_e = e_window;
      end
      ST_IDLE: begin
        run = idle_hold;
        if (accept) req_ready = onehot2(win);
      end
      default: ;
    endcase
  end

  assign lcd_rw   = 1'b0;
  assign lcd_rs   = wr_q.rs;
  assign lcd_data = wr_q.data;

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt   <= '0;
      init_idx   <= '0;
      idle_slots <= '0;
      wr_q       <= '0;
      grant      <= 2'b00;
      lock       <= 1'b0;
      last_ptr   <= 1'b1;
      init_done  <= 1'b0;
    end else begin
      case (state)
        ST_INIT_WAIT: begin
          if (slot_done) begin
            wait_cnt <= wait_cnt + 1'b1;
            if (wait_cnt == WAIT_LAST) begin
              wr_q.rs   <= 1'b0;
              wr_q.data <= INIT_TABLE[0];
            end
          end
        end
        ST_INIT_CMD: begin
          if (slot_done) begin
            if (init_idx == INIT_LAST) begin
              init_done <= 1'b1;
            end else begin
              init_idx  <= init_idx + 3'd1;
              wr_q.data <= INIT_TABLE[init_idx + 3'd1];
            end
          end
        end
        ST_IDLE: begin
          if (accept) begin
            grant      <= onehot2(win);
            lock       <= ~req_last[win];
            last_ptr   <= win;
            idle_slots <= '0;
            wr_q.rs    <= req_rs[win];
            wr_q.data  <= win ? req_data[15:8] : req_data[7:0];
          end else if (timeout) begin
            // Abandoned burst: hand priority to the other requester.
            grant      <= 2'b00;
            lock       <= 1'b0;
            last_ptr   <= grant[1];
            idle_slots <= '0;
          end else if (idle_hold) begin
            if (slot_done) idle_slots <= idle_slots + 1'b1;
          end else begin
            idle_slots <= '0;
          end
        end
        ST_SLOT: begin
          if (slot_done && !lock) grant <= 2'b00;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Scoreboard bench: expected LCD writes are queued per scenario and compared at each lcd_e rise.
module tb_lcd_bus_arbiter;

  localparam int TICK_CYC        = 4;
  localparam int SLOT_TICKS      = 4;
  localparam int INIT_WAIT_SLOTS = 2;
  localparam int LOCK_SLOTS      = 3;
  localparam int SLOT_LEN        = TICK_CYC * SLOT_TICKS;
  localparam int FIRST_RISE      = INIT_WAIT_SLOTS * SLOT_LEN + TICK_CYC;
  localparam int INIT_DONE_AT    = (INIT_WAIT_SLOTS + 6) * SLOT_LEN;
  localparam int B2B_GAP         = SLOT_LEN + 1;

  typedef struct {
    logic [1:0] grant;
    logic       rs;
    logic [7:0] data;
    int         gap_lo;
    int         gap_hi;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  req_valid;
  logic [1:0]  req_rs;
  logic [15:0] req_data;
  logic [1:0]  req_last;
  logic [1:0]  req_ready;
  logic        lcd_e;
  logic        lcd_rs;
  logic        lcd_rw;
  logic [7:0]  lcd_data;
  logic        init_done;
  logic [1:0]  grant;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         cyc     = 0;
  int         rel     = 0;
  exp_t       exp_q[$];
  logic [9:0] q0[$];
  logic [9:0] q1[$];
  logic [7:0] init_bytes[6] = '{8'h38, 8'h08, 8'h01, 8'h06, 8'h0C, 8'h02};

  lcd_bus_arbiter #(
    .TICK_CYC        (TICK_CYC),
    .SLOT_TICKS      (SLOT_TICKS),
    .INIT_WAIT_SLOTS (INIT_WAIT_SLOTS),
    .LOCK_SLOTS      (LOCK_SLOTS)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_rs    (req_rs),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .lcd_e     (lcd_e),
    .lcd_rs    (lcd_rs),
    .lcd_rw    (lcd_rw),
    .lcd_data  (lcd_data),
    .init_done (init_done),
    .grant     (grant)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk_exp(input logic [1:0] g, input logic rs, input logic [7:0] d,
                                  input int lo, input int hi);
    exp_t e;
    e.grant = g; e.rs = rs; e.data = d; e.gap_lo = lo; e.gap_hi = hi;
    return e;
  endfunction

  // Request item layout: {rs, last, data}.
  function automatic logic [9:0] mk_req(input logic rs, input logic last, input logic [7:0] d);
    return {rs, last, d};
  endfunction

  task automatic push_init();
    for (int j = 0; j < 6; j++)
      exp_q.push_back(mk_exp(2'b00, 1'b0, init_bytes[j],
                             (j == 0) ? FIRST_RISE : SLOT_LEN, (j == 0) ? FIRST_RISE : SLOT_LEN));
  endtask

  task automatic wait_init(input string tag);
    int got = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (init_done) begin
        got = cyc - rel;
        break;
      end
    end
    chk(tag, got, INIT_DONE_AT);
  endtask

  task automatic drain(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && q0.size() == 0 && q1.size() == 0) break;
    end
    chk(tag, exp_q.size() + q0.size() + q1.size(), 0);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_lcd_e"}, lcd_e, 0);
    chk({tag, "_lcd_rs"}, lcd_rs, 0);
    chk({tag, "_lcd_data"}, lcd_data, 0);
    chk({tag, "_grant"}, grant, 0);
    chk({tag, "_init_done"}, init_done, 0);
    chk({tag, "_req_ready"}, req_ready, 0);
  endtask

  // Requester model: presents queue heads and retires an item when its ready is seen.
  initial begin : driver
    logic [1:0] acc;
    req_valid = '0; req_rs = '0; req_data = '0; req_last = '0;
    forever begin
      @(negedge clk);
      acc = reset ? 2'b00 : req_ready;
      @(posedge clk);
      #1;
      if (acc[0] && q0.size() != 0) void'(q0.pop_front());
      if (acc[1] && q1.size() != 0) void'(q1.pop_front());
      req_valid[0] = (q0.size() != 0);
      req_valid[1] = (q1.size() != 0);
      {req_rs[0], req_last[0], req_data[7:0]}  = (q0.size() != 0) ? q0[0] : 10'd0;
      {req_rs[1], req_last[1], req_data[15:8]} = (q1.size() != 0) ? q1[0] : 10'd0;
    end
  end

  initial begin : monitor
    int         rise_at = 0;
    int         prev_rise = 0;
    int         gap;
    logic       prev_e = 1'b0;
    logic [8:0] held = '0;
    exp_t       e;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_e    = 1'b0;
        prev_rise = cyc + 1;
      end else begin
        if (lcd_e && !prev_e) begin
          if (exp_q.size() == 0) begin
            chk("queued_writes", exp_q.size(), 1);
          end else begin
            e = exp_q.pop_front();
            chk("wr_data", lcd_data, e.data);
            chk("wr_rs", lcd_rs, e.rs);
            chk("wr_grant", grant, e.grant);
            chk("lcd_rw", lcd_rw, 0);
            gap = cyc - prev_rise;
            if (e.gap_lo >= 0 && e.gap_lo == e.gap_hi) chk("slot_gap", gap, e.gap_lo);
            else if (e.gap_lo >= 0) chk("slot_gap_in_window", (gap >= e.gap_lo) && (gap <= e.gap_hi), 1);
          end
          rise_at   = cyc;
          prev_rise = cyc;
          held      = {lcd_rs, lcd_data};
        end
        if (!lcd_e && prev_e) begin
          chk("e_width", cyc - rise_at, TICK_CYC);
          chk("bus_hold", {lcd_rs, lcd_data}, held);
        end
        if (req_ready != 2'b00) begin
          chk("ready_after_init", init_done, 1);
          chk("ready_needs_valid", req_ready & ~req_valid, 0);
        end
        prev_e = lcd_e;
      end
    end
  end

  initial begin : watchdog
    #500_000;
    $display("FAIL watchdog: simulation did not complete, failed so far %0d", n_fail);
    $fatal(1);
  end

  initial begin : main
    push_init();
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("por");
    reset = 1'b0;
    rel = cyc;
    wait_init("init_done_cycle");
    chk("grant_after_init", grant, 0);
    drain("drain_init", 10);

    // Fair alternation with single-write bursts.
    exp_q.push_back(mk_exp(2'b01, 1'b1, 8'h31, -1, -1));
    exp_q.push_back(mk_exp(2'b10, 1'b1, 8'h32, B2B_GAP, B2B_GAP));
    exp_q.push_back(mk_exp(2'b01, 1'b1, 8'h31, B2B_GAP, B2B_GAP));
    exp_q.push_back(mk_exp(2'b10, 1'b1, 8'h32, B2B_GAP, B2B_GAP));
    for (int k = 0; k < 2; k++) begin
      q0.push_back(mk_req(1'b1, 1'b1, 8'h31));
      q1.push_back(mk_req(1'b1, 1'b1, 8'h32));
    end
    drain("drain_rr", 300);

    // Locked burst from requester 0 keeps requester 1 waiting.
    exp_q.push_back(mk_exp(2'b01, 1'b0, 8'h80, -1, -1));
    exp_q.push_back(mk_exp(2'b01, 1'b1, 8'h32, B2B_GAP, B2B_GAP));
    exp_q.push_back(mk_exp(2'b01, 1'b1, 8'h30, B2B_GAP, B2B_GAP));
    exp_q.push_back(mk_exp(2'b10, 1'b1, 8'h41, B2B_GAP, B2B_GAP));
    q0.push_back(mk_req(1'b0, 1'b0, 8'h80));
    q0.push_back(mk_req(1'b1, 1'b0, 8'h32));
    q0.push_back(mk_req(1'b1, 1'b1, 8'h30));
    q1.push_back(mk_req(1'b1, 1'b1, 8'h41));
    drain("drain_lock", 300);

    // Owner abandons its lock; released after LOCK_SLOTS idle slot periods.
    exp_q.push_back(mk_exp(2'b01, 1'b1, 8'h55, -1, -1));
    exp_q.push_back(mk_exp(2'b10, 1'b1, 8'h66,
                           (SLOT_LEN - TICK_CYC) + LOCK_SLOTS * SLOT_LEN + TICK_CYC,
                           (SLOT_LEN - TICK_CYC) + LOCK_SLOTS * SLOT_LEN + TICK_CYC + 2));
    q0.push_back(mk_req(1'b1, 1'b0, 8'h55));
    q1.push_back(mk_req(1'b1, 1'b1, 8'h66));
    drain("drain_timeout", 300);

    // Reset mid enable pulse, then a request held across the re-init.
    begin
      bit seen = 1'b0;
      exp_q.push_back(mk_exp(2'b01, 1'b1, 8'h77, -1, -1));
      q0.push_back(mk_req(1'b1, 1'b1, 8'h77));
      for (int i = 0; i < 200; i++) begin
        @(negedge clk);
        if (lcd_e && grant == 2'b01) begin
          seen = 1'b1;
          break;
        end
      end
      chk("e_high_before_reset", seen, 1);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_reset_state("mid_slot_reset");
    reset = 1'b0;
    rel = cyc;
    push_init();
    exp_q.push_back(mk_exp(2'b10, 1'b1, 8'h99, -1, -1));
    q1.push_back(mk_req(1'b1, 1'b1, 8'h99));
    wait_init("reinit_done_cycle");
    drain("drain_reinit", 100);
    repeat (SLOT_LEN) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lcd_bus_arbiter.md
LCD_BUS_ARBITER -- requirements
Module: lcd_bus_arbiter

Interface
REQ-001 SHALL use one clock; reset is synchronous and active-high.
REQ-002 SHALL have parameter TICK_CYC, default 100_000, clk cycles per 1 ms timing tick.
REQ-003 SHALL have parameter SLOT_TICKS, default 4, ticks per LCD write slot.
REQ-004 SHALL have parameter INIT_WAIT_SLOTS, default 5, idle slots after reset before the first init command.
REQ-005 SHALL have parameter LOCK_SLOTS, default 40, maximum idle slots a locked grant is held.
REQ-006 clk  in  1  system clock.
REQ-007 reset  in  1  synchronous active-high reset.
REQ-008 req_valid  in  2  per-requester write request; req0 = clock display, req1 = message writer.
REQ-009 req_rs  in  2  per-requester RS (0 command, 1 data).
REQ-010 req_data  in  16  per-requester byte, [7:0] req0, [15:8] req1.
REQ-011 req_last  in  2  marks final write of a burst; releases the lock.
REQ-012 req_ready  out  2  one-cycle accept strobe per requester.
REQ-013 lcd_e, lcd_rs  out  1 each  HD44780 enable and register select.
REQ-014 lcd_rw  out  1  tied 0.
REQ-015 lcd_data  out  8  HD44780 data bus.
REQ-016 init_done  out  1  high once the init sequence completes.
REQ-017 grant  out  2  one-hot current owner, 0 when unowned.

Function
REQ-018 SHALL implement states INIT_WAIT -> INIT_CMD -> IDLE <-> SLOT.
- INIT_WAIT: INIT_WAIT_SLOTS slots, lcd_e low.
- INIT_CMD: six RS=0 slots in order 0x38, 0x08, 0x01, 0x06, 0x0C, 0x02, then IDLE with init_done=1.
REQ-019 A slot SHALL last SLOT_TICKS*TICK_CYC cycles; lcd_rs and lcd_data SHALL be stable for the whole slot; lcd_e SHALL be high for exactly cycles [TICK_CYC, 2*TICK_CYC) of the slot.
REQ-020 In IDLE, when eligible requests exist, the block SHALL pick the winner, pulse its req_ready for one cycle, latch rs/data on that same cycle, and start the slot on the next cycle.
REQ-021 Arbitration SHALL be round-robin between requesters. After reset the last-granted pointer is 1, so requester 0 wins a simultaneous first request.
REQ-022 An accepted write with req_last=0 SHALL lock the grant: only the owner is eligible, and grant stays on the owner across IDLE.
REQ-023 An accepted write with req_last=1 SHALL clear the lock. grant SHALL drop to 0 at slot end and the pointer SHALL move to the owner.
REQ-024 If a locked owner keeps req_valid low for LOCK_SLOTS consecutive slot periods, the lock SHALL be released and the other requester becomes eligible.
REQ-025 req_ready SHALL never assert during INIT_WAIT, INIT_CMD or SLOT; requests during those states are held, not dropped.
REQ-026 Back-to-back writes SHALL have at most one IDLE cycle between slots.
REQ-027 No requester SHALL wait more than one opposing burst when both requesters use req_last=1 on every write.

Reset
REQ-028 On reset, and at any point including mid-slot with lcd_e high, the next edge SHALL produce:
- lcd_e=0, lcd_rs=0, lcd_data=0x00;
- req_ready=0, grant=0, init_done=0;
- lock cleared, state INIT_WAIT, all timers 0.

Structure
REQ-029 Package lcd_pkg SHALL hold the HD44780 command constants (function set, display off/on, clear, entry mode, return home, set line1 0x80, set line2 0xC0), the six-entry init table and the state encoding.
REQ-030 Sub-module lcd_slot_timer SHALL generate the tick, the slot_done pulse and the e-window from TICK_CYC and SLOT_TICKS; the arbiter FSM stays in lcd_bus_arbiter.

Verification (TICK_CYC=4, SLOT_TICKS=4, INIT_WAIT_SLOTS=2, LOCK_SLOTS=3)
REQ-031 Release reset, no requests:
- 32 idle cycles, then lcd_data 0x38, 0x08, 0x01, 0x06, 0x0C, 0x02, each held 16 cycles;
- lcd_e high on cycles 4-7 of each slot;
- init_done rises after the sixth slot.
REQ-032 After init, both req_valid high, req_data=0x31/0x32, req_rs=1, req_last=1:
- ready[0] fires first, bus carries 0x31, then 0x32;
- the order alternates on later repeats.
REQ-033 req0 sends 0x80 with last=0 while req1 is valid:
- grant stays 01 for the following req0 writes 0x32, 0x30 (last=1);
- req1 is granted only after 0x30.
REQ-034 req0 locks, then drops valid:
- after 3 slot periods (48 cycles) grant moves to 10 and req1 data appears on the bus.
REQ-035 Assert reset for 1 cycle during the lcd_e-high window of a data slot:
- next cycle lcd_e=0, grant=0, init_done=0;
- the init sequence restarts from INIT_WAIT.
